// File: rtl/ysyx_24080014_wbu_pkg.sv
// Shared encodings for the ysyx_24080014 writeback unit:
// rd source selects, load funct3 codes and the WBU state type.
package ysyx_24080014_wbu_pkg;

    localparam logic [2:0] RD_PC        = 3'b000;
    localparam logic [2:0] RD_PC_ADD    = 3'b001;
    localparam logic [2:0] RD_ALU_OUT   = 3'b010;
    localparam logic [2:0] RD_IMM       = 3'b011;
    localparam logic [2:0] RD_READ_DATA = 3'b100;
    localparam logic [2:0] RD_CSR       = 3'b101;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/ysyx_24080014_load_ext.sv
// Combinational load extractor: picks the byte/halfword addressed by
// offset out of a word-aligned read and sign/zero extends it.
module ysyx_24080014_load_ext
    import ysyx_24080014_wbu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data,
    output logic            bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
        // misaligned halves are not trapped; offset[0] is ignored
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        bad  = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data = rdata;
            default: bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_24080014_wbu.sv
// Registered writeback unit: selects rd data, waits on load responses,
// drives the register-file write port and the retire pulse.
module ysyx_24080014_wbu
    import ysyx_24080014_wbu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu_out,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_csr_rdata,
    input  logic [2:0]        in_rd_ctl,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_rd_wen,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    wbu_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [XLEN-1:0]   ld_pc;
    logic [REG_AW-1:0] ld_rd;
    logic              ld_wen;
    logic [2:0]        ld_f3;
    logic [1:0]        ld_off;

    logic [XLEN-1:0] ext_data;
    logic            ext_bad;
    logic [XLEN-1:0] src_data;
    logic            accept;
    logic            ld_done;
    logic            ld_timeout;

    assign in_ready   = (state == S_IDLE);
    assign mem_rready = (state == S_WAIT_LOAD);
    assign accept     = in_valid && in_ready;
    assign ld_done    = (state == S_WAIT_LOAD) && mem_rvalid;
    // a response arriving on the limit cycle still wins
    assign ld_timeout = (state == S_WAIT_LOAD) && !mem_rvalid
                     && (cnt == CNT_LIMIT);

    ysyx_24080014_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rdata (mem_rdata),
        .funct3(ld_f3),
        .offset(ld_off),
        .data  (ext_data),
        .bad   (ext_bad)
    );

    always_comb begin
        src_data = '0;
        case (in_rd_ctl)
            RD_PC:        src_data = in_pc;
            RD_PC_ADD:    src_data = in_pc + XLEN'(4);
            RD_ALU_OUT:   src_data = in_alu_out;
            RD_IMM:       src_data = in_imm;
            RD_READ_DATA: src_data = '0;
            RD_CSR:       src_data = in_csr_rdata;
            default:      src_data = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept && in_is_load) begin
                    state_nxt = S_WAIT_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOAD: begin
                if (mem_rvalid || ld_timeout) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_pc  <= '0;
            ld_rd  <= '0;
            ld_wen <= 1'b0;
            ld_f3  <= '0;
            ld_off <= '0;
        end else if (accept && in_is_load) begin
            ld_pc  <= in_pc;
            ld_rd  <= in_rd_addr;
            ld_wen <= in_rd_wen;
            ld_f3  <= in_funct3;
            ld_off <= in_alu_out[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            err          <= 1'b0;
        end else begin
            rf_wen       <= 1'b0;
            commit_valid <= 1'b0;
            if (accept && !in_is_load) begin
                rf_wen       <= in_rd_wen && (in_rd_addr != '0);
                rf_waddr     <= in_rd_addr;
                rf_wdata     <= src_data;
                commit_valid <= 1'b1;
                commit_pc    <= in_pc;
            end else if (ld_done) begin
                rf_wen       <= ld_wen && (ld_rd != '0);
                rf_waddr     <= ld_rd;
                rf_wdata     <= ext_data;
                commit_valid <= 1'b1;
                commit_pc    <= ld_pc;
                if (ext_bad) begin
                    err <= 1'b1;
                end
            end
            if (ld_timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Testbench for ysyx_24080014_wbu: directed scenarios with literal
// expectations plus random traffic against a behavioural model.
module tb_ysyx_24080014_wbu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_alu_out;
    logic [31:0] in_imm;
    logic [31:0] in_csr_rdata;
    logic [2:0]  in_rd_ctl;
    logic [4:0]  in_rd_addr;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        err;

    always #5 clk = ~clk;

    ysyx_24080014_wbu #(
        .XLEN(32),
        .REG_AW(5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_alu_out(in_alu_out),
        .in_imm(in_imm),
        .in_csr_rdata(in_csr_rdata),
        .in_rd_ctl(in_rd_ctl),
        .in_rd_addr(in_rd_addr),
        .in_rd_wen(in_rd_wen),
        .in_is_load(in_is_load),
        .in_funct3(in_funct3),
        .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .mem_rdata(mem_rdata),
        .rf_wen(rf_wen),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .commit_valid(commit_valid),
        .commit_pc(commit_pc),
        .err(err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] src_model(input logic [2:0] ctl,
        input logic [31:0] pc, input logic [31:0] alu,
        input logic [31:0] imm, input logic [31:0] csr);
        case (ctl)
            3'd0: return pc;
            3'd1: return pc + 32'd4;
            3'd2: return alu;
            3'd3: return imm;
            3'd5: return csr;
            default: return 32'd0;
        endcase
    endfunction

    // {bad, data}
    function automatic logic [32:0] ext_model(input logic [31:0] w,
        input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0: return {1'b0, (b >= 128) ? b - 32'd256 : b};
            3'd1: return {1'b0, (h >= 32768) ? h - 32'd65536 : h};
            3'd2: return {1'b0, w};
            3'd4: return {1'b0, b};
            3'd5: return {1'b0, h};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    bit          m_busy;
    int          m_waited;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    bit          m_wen;
    logic [2:0]  m_f3;
    logic [1:0]  m_a;
    bit          e_wen;
    bit          e_cv;
    bit          e_err;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_pc;
    logic [32:0] m_r;

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd,
                          input bit wen, input logic [31:0] d);
        e_cv    = 1'b1;
        e_pc    = pc;
        e_wen   = wen && (rd != 5'd0);
        e_waddr = rd;
        e_wdata = d;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_waited = 0;
            e_wen    = 1'b0;
            e_cv     = 1'b0;
            e_err    = 1'b0;
            e_waddr  = '0;
            e_wdata  = '0;
            e_pc     = '0;
        end else begin
            e_wen = 1'b0;
            e_cv  = 1'b0;
            if (!m_busy) begin
                if (in_valid && in_is_load) begin
                    m_busy   = 1'b1;
                    m_waited = 0;
                    m_pc     = in_pc;
                    m_rd     = in_rd_addr;
                    m_wen    = in_rd_wen;
                    m_f3     = in_funct3;
                    m_a      = in_alu_out[1:0];
                end else if (in_valid) begin
                    retire(in_pc, in_rd_addr, in_rd_wen,
                           src_model(in_rd_ctl, in_pc, in_alu_out,
                                     in_imm, in_csr_rdata));
                end
            end else if (mem_rvalid) begin
                m_r = ext_model(mem_rdata, m_f3, m_a);
                if (m_r[32]) e_err = 1'b1;
                retire(m_pc, m_rd, m_wen, m_r[31:0]);
                m_busy = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    e_err  = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("mem_rready", 32'(mem_rready), 32'(m_busy));
            chk("rf_wen", 32'(rf_wen), 32'(e_wen));
            chk("commit_valid", 32'(commit_valid), 32'(e_cv));
            chk("err", 32'(err), 32'(e_err));
            if (e_wen) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
                chk("rf_wdata", rf_wdata, e_wdata);
            end
            if (e_cv) chk("commit_pc", commit_pc, e_pc);
        end
    end

    task automatic drive_op(input logic [31:0] pc,
        input logic [31:0] alu, input logic [31:0] imm,
        input logic [2:0] ctl, input logic [4:0] rd,
        input logic wen, input logic ld, input logic [2:0] f3);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_alu_out   = alu;
        in_imm       = imm;
        in_csr_rdata = 32'hC5C5_0000;
        in_rd_ctl    = ctl;
        in_rd_addr   = rd;
        in_rd_wen    = wen;
        in_is_load   = ld;
        in_funct3    = f3;
    endtask

    task automatic do_load(input logic [31:0] addr,
        input logic [2:0] f3, input logic [31:0] rdata,
        input int delay, input logic [31:0] want, input string nm);
        drive_op(32'h8000_0200, addr, 32'd0, 3'd0, 5'd9, 1'b1, 1'b1,
                 f3);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < delay; i++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk({nm, "_wen"}, 32'(rf_wen), 32'd1);
        chk({nm, "_data"}, rf_wdata, want);
    endtask

    initial begin
        drive_op(32'd0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 3'd0);
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_commit", 32'(commit_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wdata", rf_wdata, 32'd0);
        rst = 1'b0;

        @(negedge clk);
        drive_op(32'h8000_0100, 32'h1000, 32'd0, 3'd0, 5'd7, 1'b1,
                 1'b1, 3'd2);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstld_wen", 32'(rf_wen), 32'd0);
        chk("rstld_commit", 32'(commit_valid), 32'd0);
        chk("rstld_ready", 32'(in_ready), 32'd1);
        chk("rstld_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        drive_op(32'h8000_0000, 32'd0, 32'd0, 3'b001, 5'd5, 1'b1,
                 1'b0, 3'd0);
        @(negedge clk);
        chk("b2b0_wen", 32'(rf_wen), 32'd1);
        chk("b2b0_data", rf_wdata, 32'h8000_0004);
        chk("b2b0_addr", 32'(rf_waddr), 32'd5);
        drive_op(32'h8000_0004, 32'd0, 32'h123, 3'b011, 5'd6, 1'b1,
                 1'b0, 3'd0);
        @(negedge clk);
        chk("b2b1_wen", 32'(rf_wen), 32'd1);
        chk("b2b1_data", rf_wdata, 32'h0000_0123);
        chk("b2b1_addr", 32'(rf_waddr), 32'd6);
        drive_op(32'h8000_0008, 32'hDEAD_BEEF, 32'd0, 3'b010, 5'd0,
                 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("x0_commit", 32'(commit_valid), 32'd1);
        chk("x0_wen", 32'(rf_wen), 32'd0);
        chk("x0_pc", commit_pc, 32'h8000_0008);

        do_load(32'h1002, 3'b000, 32'h80F0_7F01, 3, 32'hFFFF_FFF0,
                "lb2");
        do_load(32'h1003, 3'b100, 32'h80F0_7F01, 2, 32'h0000_0080,
                "lbu3");
        do_load(32'h1002, 3'b001, 32'h80F0_7F01, 1, 32'hFFFF_80F0,
                "lh2");
        do_load(32'h1001, 3'b101, 32'h80F0_7F01, 4, 32'h0000_7F01,
                "lhu1");
        chk("pre_err", 32'(err), 32'd0);
        do_load(32'h1000, 3'b011, 32'h80F0_7F01, 1, 32'd0, "bad");
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_commit", 32'(commit_valid), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_op(32'h8000_0300, 32'h2000, 32'd0, 3'd0, 5'd3, 1'b1,
                 1'b1, 3'd2);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_wait_ready", 32'(in_ready), 32'd0);
        chk("to_wait_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("to_ready", 32'(in_ready), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_commit", 32'(commit_valid), 32'd0);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_wen", 32'(rf_wen), 32'd0);
        chk("late_commit", 32'(commit_valid), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            in_valid     = 1'($urandom_range(0, 1));
            in_pc        = ($urandom_range(0, 15) == 0)
                         ? 32'hFFFF_FFFC : $urandom;
            in_alu_out   = $urandom;
            in_imm       = $urandom;
            in_csr_rdata = $urandom;
            in_rd_ctl    = 3'($urandom_range(0, 7));
            in_rd_addr   = ($urandom_range(0, 7) == 0)
                         ? 5'd0 : 5'($urandom_range(1, 31));
            in_rd_wen    = ($urandom_range(0, 3) != 0);
            in_is_load   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 15))
                0:       in_funct3 = 3'($urandom_range(0, 7));
                1, 2, 3: in_funct3 = 3'd0;
                4, 5, 6: in_funct3 = 3'd1;
                7, 8, 9: in_funct3 = 3'd4;
                10, 11:  in_funct3 = 3'd5;
                default: in_funct3 = 3'd2;
            endcase
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        rst        = 1'b0;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec,
                 n_bad);
        $finish;
    end

endmodule
